// File: rtl/dmem_requester.sv
// -----------------------------------------------------------------------------
// dmem_requester
//
// CPU-side initiator for the data port of the shared instruction/data memory.
// Turns single-word load/store requests from the MEM stage into the memory's
// d_readM / d_writeM / d_address / d_data protocol. For a load it holds
// d_readM for LATENCY cycles, spends one capture cycle sampling d_data, then
// returns the word with a one-cycle cpu_rvalid pulse. A store is a single
// d_writeM cycle with no completion pulse.
//
// Build option:
//   DMEM_WRITE_BUFFER_EN  defined   -> one-entry posted-write buffer. Stores
//                                      can be accepted during a load and are
//                                      drained in IDLE ahead of the next load.
//                         undefined -> no buffer; one request at a time,
//                                      accepted only in IDLE.
//
// Parameters:
//   LATENCY    memory read latency in cycles (legal 1..3)
//   WORD_SIZE  data and address width
//
// Ports:
//   clk         clock, rising edge
//   reset_n     asynchronous active-low reset
//   cpu_req     request valid
//   cpu_we      1 = store, 0 = load (qualified by cpu_req)
//   cpu_addr    word address
//   cpu_wdata   store data
//   cpu_ready   request accepted on an edge where cpu_req && cpu_ready
//   cpu_rdata   registered load data
//   cpu_rvalid  one-cycle pulse, cpu_rdata valid in that cycle
//   d_readM     memory read strobe
//   d_writeM    memory write strobe
//   d_address   memory address (holds its last value between accesses)
//   d_data      memory data bus, driven only while d_writeM=1
// -----------------------------------------------------------------------------
module dmem_requester #(
    parameter int LATENCY   = 2,
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic                 cpu_ready,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_rvalid,
    output logic                 d_readM,
    output logic                 d_writeM,
    output logic [WORD_SIZE-1:0] d_address,
    inout  wire  [WORD_SIZE-1:0] d_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    // The memory counts its latency with a 2-bit counter, so cnt never needs
    // more than two bits; the last RD cycle is the one where cnt hits this.
    localparam logic [1:0] CNT_LAST = 2'(LATENCY - 1);

    state_t                 state_reg, state_next;
    logic [1:0]             cnt_reg, cnt_next;
    logic [WORD_SIZE-1:0]   addr_reg, addr_next;
    logic [WORD_SIZE-1:0]   rdata_reg, rdata_next;
    logic                   rvalid_reg, rvalid_next;

    logic                   accept_ld;
    logic                   accept_st;
    logic [WORD_SIZE-1:0]   wr_word;

`ifdef DMEM_WRITE_BUFFER_EN
    logic                   buf_valid_reg, buf_valid_next;
    logic [WORD_SIZE-1:0]   buf_addr_reg, buf_addr_next;
    logic [WORD_SIZE-1:0]   buf_data_reg, buf_data_next;

    // A store only needs a free buffer slot; a load additionally needs the
    // FSM idle. Loads are also held off while a store is buffered so the
    // store reaches memory first (program order).
    always_comb begin
        cpu_ready = !buf_valid_reg && (cpu_we || (state_reg == ST_IDLE));
        accept_st = cpu_req && cpu_we && !buf_valid_reg;
        accept_ld = cpu_req && !cpu_we && !buf_valid_reg && (state_reg == ST_IDLE);
    end

    // The buffer itself is the write holding register: WR always drives it.
    assign wr_word = buf_data_reg;
`else
    logic [WORD_SIZE-1:0]   wdata_reg, wdata_next;

    always_comb begin
        cpu_ready = (state_reg == ST_IDLE);
        accept_st = cpu_req && cpu_we && cpu_ready;
        accept_ld = cpu_req && !cpu_we && cpu_ready;
    end

    assign wr_word = wdata_reg;
`endif

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 2'd0;
            addr_reg   <= '0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            addr_reg   <= addr_next;
            rdata_reg  <= rdata_next;
            rvalid_reg <= rvalid_next;
        end
    end

`ifdef DMEM_WRITE_BUFFER_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid_reg <= 1'b0;
            buf_addr_reg  <= '0;
            buf_data_reg  <= '0;
        end else begin
            buf_valid_reg <= buf_valid_next;
            buf_addr_reg  <= buf_addr_next;
            buf_data_reg  <= buf_data_next;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdata_reg <= '0;
        end else begin
            wdata_reg <= wdata_next;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        addr_next   = addr_reg;
        rdata_next  = rdata_reg;
        rvalid_next = 1'b0;
`ifdef DMEM_WRITE_BUFFER_EN
        buf_valid_next = buf_valid_reg;
        buf_addr_next  = buf_addr_reg;
        buf_data_next  = buf_data_reg;

        // Any accepted store lands in the buffer, whatever the FSM is doing.
        // The buffer is never full when a store is accepted, so this cannot
        // collide with the clear at the end of WR below.
        if (accept_st) begin
            buf_valid_next = 1'b1;
            buf_addr_next  = cpu_addr;
            buf_data_next  = cpu_wdata;
        end
`else
        wdata_next = wdata_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
`ifdef DMEM_WRITE_BUFFER_EN
                if (buf_valid_reg) begin
                    // Drain a store posted during the previous load.
                    state_next = ST_WR;
                    addr_next  = buf_addr_reg;
                end else if (accept_st) begin
                    // Buffer is empty and the FSM is free: write straight
                    // away so an idle store keeps single-cycle timing.
                    state_next = ST_WR;
                    addr_next  = cpu_addr;
                end else if (accept_ld) begin
                    state_next = ST_RD;
                    cnt_next   = 2'd0;
                    addr_next  = cpu_addr;
                end
`else
                if (accept_st) begin
                    state_next = ST_WR;
                    addr_next  = cpu_addr;
                    wdata_next = cpu_wdata;
                end else if (accept_ld) begin
                    state_next = ST_RD;
                    cnt_next   = 2'd0;
                    addr_next  = cpu_addr;
                end
`endif
            end

            ST_RD: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_CAP;
                    cnt_next   = 2'd0;
                end else begin
                    cnt_next = cnt_reg + 2'd1;
                end
            end

            ST_CAP: begin
                // Memory presents the word during this cycle; sample it on
                // the closing edge and flag it for the following IDLE cycle.
                state_next  = ST_IDLE;
                rdata_next  = d_data;
                rvalid_next = 1'b1;
            end

            ST_WR: begin
                state_next = ST_IDLE;
`ifdef DMEM_WRITE_BUFFER_EN
                buf_valid_next = 1'b0;
`endif
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = 2'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Strobes decode straight from the state register, so read and write can
    // never be asserted together and both drop immediately on reset.
    assign d_readM    = (state_reg == ST_RD);
    assign d_writeM   = (state_reg == ST_WR);
    assign d_address  = addr_reg;
    assign cpu_rdata  = rdata_reg;
    assign cpu_rvalid = rvalid_reg;

    // Only drive the shared bus during the write cycle.
    assign d_data = d_writeM ? wr_word : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_dmem_requester.sv
// -----------------------------------------------------------------------------
// tb_dmem_requester
//
// Directed bench for dmem_requester. A small behavioural memory answers reads
// in the cycle after d_readM falls and commits writes on the edge closing a
// d_writeM cycle. Whether the DUT releases d_data is probed by having the
// bench drive all-zeros onto the bus in cycles where nobody else should: any
// contribution from the DUT makes the bus read back non-zero.
// -----------------------------------------------------------------------------
module tb_dmem_requester;

    parameter int LAT = 2;
    localparam int RV = LAT + 2;    // accept edge to cpu_rvalid cycle

    logic        clk;
    logic        reset_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        d_readM;
    logic        d_writeM;
    logic [15:0] d_address;
    wire  [15:0] d_data;

    int n_cmp = 0;
    int n_err = 0;

    dmem_requester #(.LATENCY(LAT), .WORD_SIZE(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .d_readM    (d_readM),
        .d_writeM   (d_writeM),
        .d_address  (d_address),
        .d_data     (d_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------ memory
    logic [15:0] mem [0:255];
    logic        prev_readM;
    logic        mem_init;
    logic        probe_en;
    logic        mem_drive;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_readM <= 1'b0;
        else          prev_readM <= d_readM;
    end

    always @(posedge clk) begin
        if (mem_init) begin
            mem[8'h01] <= 16'h0001;
            mem[8'h02] <= 16'hFFFF;
            mem[8'h23] <= 16'h6000;
            mem[8'h10] <= 16'h0000;
            mem[8'hF0] <= 16'h0000;
        end else if (d_writeM) begin
            mem[d_address[7:0]] <= d_data;
        end
    end

    assign mem_drive = prev_readM && !d_readM;
    assign d_data = mem_drive ? mem[d_address[7:0]] : (probe_en ? 16'h0000 : 16'hzzzz);

    // ------------------------------------------------------------------- tests
    task automatic test_reset();
        @(negedge clk);
        probe_en = 1'b1;
        #1;
        n_cmp++; if (cpu_ready !== 1'b1)     begin n_err++; $display("FAIL reset_ready: got %b want 1", cpu_ready); end
        n_cmp++; if (d_readM !== 1'b0)       begin n_err++; $display("FAIL reset_readM: got %b want 0", d_readM); end
        n_cmp++; if (d_writeM !== 1'b0)      begin n_err++; $display("FAIL reset_writeM: got %b want 0", d_writeM); end
        n_cmp++; if (cpu_rvalid !== 1'b0)    begin n_err++; $display("FAIL reset_rvalid: got %b want 0", cpu_rvalid); end
        n_cmp++; if (cpu_rdata !== 16'h0000) begin n_err++; $display("FAIL reset_rdata: got %h want 0000", cpu_rdata); end
        n_cmp++; if (d_address !== 16'h0000) begin n_err++; $display("FAIL reset_addr: got %h want 0000", d_address); end
        n_cmp++; if (d_data !== 16'h0000)    begin n_err++; $display("FAIL reset_bus_released: got %h want 0000", d_data); end
        probe_en = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
        n_cmp++; if (cpu_ready !== 1'b1)     begin n_err++; $display("FAIL reset_ready_release: got %b want 1", cpu_ready); end
        $display("reset: checked idle state");
    endtask

    task automatic test_single_load();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
        @(posedge clk);
        for (int k = 1; k <= RV + 2; k++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            n_cmp++; if (d_readM !== (k <= LAT)) begin n_err++; $display("FAIL load1_readM c%0d: got %b want %b", k, d_readM, (k <= LAT)); end
            n_cmp++; if (cpu_rvalid !== (k == RV)) begin n_err++; $display("FAIL load1_rvalid c%0d: got %b want %b", k, cpu_rvalid, (k == RV)); end
            if (k <= LAT + 1) begin
                n_cmp++; if (d_address !== 16'h0001) begin n_err++; $display("FAIL load1_addr c%0d: got %h want 0001", k, d_address); end
            end
            if (k >= RV) begin
                n_cmp++; if (cpu_rdata !== 16'h0001) begin n_err++; $display("FAIL load1_rdata c%0d: got %h want 0001", k, cpu_rdata); end
            end
        end
        $display("load  addr=0001 rdata=%h", cpu_rdata);
    endtask

    task automatic test_reset_mid_rd();
        int rv_seen;
        int rd_seen;
        rv_seen = 0;
        rd_seen = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0002;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        n_cmp++; if (d_readM !== 1'b1) begin n_err++; $display("FAIL midrd_readM_before: got %b want 1", d_readM); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (d_readM !== 1'b0)       begin n_err++; $display("FAIL midrd_readM_drop: got %b want 0", d_readM); end
        n_cmp++; if (d_address !== 16'h0000) begin n_err++; $display("FAIL midrd_addr: got %h want 0000", d_address); end
        n_cmp++; if (cpu_rdata !== 16'h0000) begin n_err++; $display("FAIL midrd_rdata: got %h want 0000", cpu_rdata); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL midrd_ready: got %b want 1", cpu_ready); end
        for (int k = 0; k < RV + 4; k++) begin
            @(negedge clk);
            if (cpu_rvalid) rv_seen++;
            if (d_readM)    rd_seen++;
        end
        n_cmp++; if (rv_seen != 0) begin n_err++; $display("FAIL midrd_no_rvalid: got %0d pulses want 0", rv_seen); end
        n_cmp++; if (rd_seen != 0) begin n_err++; $display("FAIL midrd_no_readM: got %0d cycles want 0", rd_seen); end
        $display("reset mid-RD: load dropped");
    endtask

    task automatic test_store_load();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h00F0; cpu_wdata = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0;
        n_cmp++; if (d_writeM !== 1'b1)      begin n_err++; $display("FAIL st_writeM: got %b want 1", d_writeM); end
        n_cmp++; if (d_readM !== 1'b0)       begin n_err++; $display("FAIL st_readM: got %b want 0", d_readM); end
        n_cmp++; if (d_data !== 16'hBEEF)    begin n_err++; $display("FAIL st_data: got %h want beef", d_data); end
        n_cmp++; if (d_address !== 16'h00F0) begin n_err++; $display("FAIL st_addr: got %h want 00f0", d_address); end
        n_cmp++; if (cpu_ready !== 1'b0)     begin n_err++; $display("FAIL st_ready_wr: got %b want 0", cpu_ready); end
        @(negedge clk);
        probe_en = 1'b1;
        #1;
        n_cmp++; if (d_writeM !== 1'b0)   begin n_err++; $display("FAIL st_writeM_after: got %b want 0", d_writeM); end
        n_cmp++; if (cpu_ready !== 1'b1)  begin n_err++; $display("FAIL st_ready_back: got %b want 1", cpu_ready); end
        n_cmp++; if (d_data !== 16'h0000) begin n_err++; $display("FAIL st_bus_released: got %h want 0000", d_data); end
        probe_en = 1'b0;
        $display("store addr=00f0 wdata=beef");
        // Read it back, accepted on the next edge.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h00F0;
        @(posedge clk);
        for (int k = 1; k <= RV; k++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            if (k <= LAT) begin
                probe_en = 1'b1;
                #1;
                n_cmp++; if (d_data !== 16'h0000) begin n_err++; $display("FAIL ld_bus_released c%0d: got %h want 0000", k, d_data); end
                probe_en = 1'b0;
            end
        end
        n_cmp++; if (cpu_rvalid !== 1'b1)    begin n_err++; $display("FAIL ld_f0_rvalid: got %b want 1", cpu_rvalid); end
        n_cmp++; if (cpu_rdata !== 16'hBEEF) begin n_err++; $display("FAIL ld_f0_rdata: got %h want beef", cpu_rdata); end
        $display("load  addr=00f0 rdata=%h", cpu_rdata);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0002;
        @(posedge clk);
        for (int k = 1; k <= 2 * RV + 1; k++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            n_cmp++; if (cpu_rvalid !== ((k == RV) || (k == 2 * RV)))
                begin n_err++; $display("FAIL b2b_rvalid c%0d: got %b want %b", k, cpu_rvalid, ((k == RV) || (k == 2 * RV))); end
            if (k == RV) begin
                n_cmp++; if (cpu_rdata !== 16'hFFFF) begin n_err++; $display("FAIL b2b_rdata1: got %h want ffff", cpu_rdata); end
                cpu_req = 1'b1; cpu_addr = 16'h0023;
                #1;
                n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_in_rvalid: got %b want 1", cpu_ready); end
                $display("load  addr=0002 rdata=%h", cpu_rdata);
            end
            if (k == 2 * RV) begin
                n_cmp++; if (cpu_rdata !== 16'h6000) begin n_err++; $display("FAIL b2b_rdata2: got %h want 6000", cpu_rdata); end
                $display("load  addr=0023 rdata=%h", cpu_rdata);
            end
        end
    endtask

`ifdef DMEM_WRITE_BUFFER_EN
    task automatic test_write_buffer();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
        @(posedge clk);
        for (int k = 1; k <= RV + 2; k++) begin
            @(negedge clk);
            cpu_req = 1'b0; cpu_we = 1'b0;
            if (k == 1) begin
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'h1234;
                #1;
                n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL wb_store_ready_rd: got %b want 1", cpu_ready); end
            end else if (k <= RV) begin
                #1;
                n_cmp++; if (d_writeM !== 1'b0)      begin n_err++; $display("FAIL wb_no_write_early c%0d: got %b want 0", k, d_writeM); end
                n_cmp++; if (cpu_ready !== 1'b0)     begin n_err++; $display("FAIL wb_load_blocked c%0d: got %b want 0", k, cpu_ready); end
                if (k <= LAT + 1) begin
                    n_cmp++; if (d_address !== 16'h0001) begin n_err++; $display("FAIL wb_addr_held c%0d: got %h want 0001", k, d_address); end
                end
                if (k == RV) begin
                    n_cmp++; if (cpu_rvalid !== 1'b1)    begin n_err++; $display("FAIL wb_rvalid: got %b want 1", cpu_rvalid); end
                    n_cmp++; if (cpu_rdata !== 16'h0001) begin n_err++; $display("FAIL wb_rdata: got %h want 0001", cpu_rdata); end
                end
            end else if (k == RV + 1) begin
                n_cmp++; if (d_writeM !== 1'b1)      begin n_err++; $display("FAIL wb_drain_writeM: got %b want 1", d_writeM); end
                n_cmp++; if (d_address !== 16'h0010) begin n_err++; $display("FAIL wb_drain_addr: got %h want 0010", d_address); end
                n_cmp++; if (d_data !== 16'h1234)    begin n_err++; $display("FAIL wb_drain_data: got %h want 1234", d_data); end
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h5555;
                #1;
                n_cmp++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL wb_store_in_wr: got %b want 0", cpu_ready); end
            end else begin
                n_cmp++; if (d_writeM !== 1'b0) begin n_err++; $display("FAIL wb_writeM_end: got %b want 0", d_writeM); end
            end
        end
        $display("store addr=0010 wdata=1234 (posted)");
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        @(posedge clk);
        for (int k = 1; k <= RV; k++) begin
            @(negedge clk);
            cpu_req = 1'b0;
        end
        n_cmp++; if (cpu_rvalid !== 1'b1)    begin n_err++; $display("FAIL wb_ld10_rvalid: got %b want 1", cpu_rvalid); end
        n_cmp++; if (cpu_rdata !== 16'h1234) begin n_err++; $display("FAIL wb_ld10_rdata: got %h want 1234", cpu_rdata); end
        $display("load  addr=0010 rdata=%h", cpu_rdata);
    endtask
`endif

    // ------------------------------------------------------------------- main
    initial begin
        reset_n   = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 16'h0000;
        mem_init  = 1'b1;
        probe_en  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;

        test_reset();
        test_single_load();
        test_reset_mid_rd();
        test_store_load();
        test_back_to_back();
`ifdef DMEM_WRITE_BUFFER_EN
        test_write_buffer();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
